ucie_ctl_rx_mod_top: RTL and testbench

Receive-path control block of the UCIe adapter. It is the counterpart of the TX module: it takes 64-bit flits from the RDI (physical layer side), buffers them in an internal FIFO, and delivers them to the protocol layer over the FDI with a valid/ready handshake. It follows the FDI link state: it is active only while the link is ACTIVE, and it flags a sticky overflow error when the RDI pushes into a full buffer.

---
 rtl/ucie_ctl_rx_mod_top.sv | 134 +++++++++++++
 tb/tb_ucie_ctl_rx_mod_top.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucie_ctl_rx_mod_top.sv
// UCIe adapter receive control: buffers RDI flits in a first-word-fall-through FIFO
// and hands them to the FDI over valid/ready, tracking link state and overflow.
module ucie_ctl_rx_mod_top #(
    parameter int UCIE_ACTIVE = 1,
    parameter int FIFO_P_SIZE = 3,
    parameter int FIFO_DEPTH  = 8,
    parameter int FIFO_D_SIZE = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [3:0]             i_fdi_pl_state_sts,
    input  logic                   i_rdi_pl_valid,
    input  logic [FIFO_D_SIZE-1:0] i_rdi_pl_data,
    input  logic                   i_fdi_lp_rxrdy,
    output logic                   o_fdi_pl_valid,
    output logic [FIFO_D_SIZE-1:0] o_fdi_pl_data,
    output logic                   o_rx_overf_err,
    output logic [FIFO_P_SIZE:0]   o_rx_fifo_level
);

    localparam logic [3:0]             ACTIVE_STS = 4'(UCIE_ACTIVE);
    localparam logic [FIFO_P_SIZE:0]   DEPTH_CNT  = (FIFO_P_SIZE + 1)'(FIFO_DEPTH);
    localparam logic [FIFO_P_SIZE-1:0] PTR_ONE    = {{(FIFO_P_SIZE - 1){1'b0}}, 1'b1};
    localparam logic [FIFO_P_SIZE:0]   CNT_ONE    = {{FIFO_P_SIZE{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        RESET_RX    = 2'd0,
        ACTIVE_RX   = 2'd1,
        OVERFLOW_RX = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [FIFO_D_SIZE-1:0] mem [FIFO_DEPTH];
    logic [FIFO_P_SIZE-1:0] wr_ptr_reg, wr_ptr_next;
    logic [FIFO_P_SIZE-1:0] rd_ptr_reg, rd_ptr_next;
    logic [FIFO_P_SIZE:0]   count_reg, count_next;

    logic link_up;
    logic fifo_empty;
    logic fifo_full;
    logic pl_valid;
    logic pop;
    logic push;
    logic overflow;
    logic flush;

    always_comb begin
        link_up    = (i_fdi_pl_state_sts == ACTIVE_STS);
        fifo_empty = (count_reg == '0);
        fifo_full  = (count_reg == DEPTH_CNT);
        pl_valid   = (state_reg != RESET_RX) && !fifo_empty;
        pop        = pl_valid && i_fdi_lp_rxrdy;
        // A full buffer still accepts a flit when the head leaves in the same cycle.
        push       = (state_reg == ACTIVE_RX) && link_up && i_rdi_pl_valid && (!fifo_full || pop);
        overflow   = (state_reg == ACTIVE_RX) && i_rdi_pl_valid && fifo_full && !pop;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RESET_RX: begin
                if (link_up) begin
                    state_next = ACTIVE_RX;
                end
            end
            ACTIVE_RX: begin
                if (!link_up) begin
                    state_next = RESET_RX;
                end else if (overflow) begin
                    state_next = OVERFLOW_RX;
                end
            end
            OVERFLOW_RX: begin
                if (!link_up) begin
                    state_next = RESET_RX;
                end
            end
            default: state_next = RESET_RX;
        endcase
    end

    // Losing the link discards everything buffered, so any edge landing in RESET_RX flushes.
    always_comb begin
        flush       = (state_next == RESET_RX);
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg  <= RESET_RX;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= i_rdi_pl_data;
        end
    end

    // Data is forced to zero while nothing is presented so reset leaves every output at 0.
    assign o_fdi_pl_valid  = pl_valid;
    assign o_fdi_pl_data   = pl_valid ? mem[rd_ptr_reg] : '0;
    assign o_rx_overf_err  = (state_reg == OVERFLOW_RX);
    assign o_rx_fifo_level = count_reg;

endmodule

// File: tb/tb_ucie_ctl_rx_mod_top.sv
// Randomised bench for ucie_ctl_rx_mod_top against a queue-based model of the receive path.
module tb_ucie_ctl_rx_mod_top;

    localparam logic [3:0] STS_ACTIVE = 4'd1;
    localparam logic [3:0] STS_LINK_ERROR = 4'd10;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [3:0]  i_fdi_pl_state_sts;
    logic        i_rdi_pl_valid;
    logic [63:0] i_rdi_pl_data;
    logic        i_fdi_lp_rxrdy;
    logic        o_fdi_pl_valid;
    logic [63:0] o_fdi_pl_data;
    logic        o_rx_overf_err;
    logic [3:0]  o_rx_fifo_level;

    always #5 i_clk = ~i_clk;

    ucie_ctl_rx_mod_top #(
        .UCIE_ACTIVE(1),
        .FIFO_P_SIZE(3),
        .FIFO_DEPTH (8),
        .FIFO_D_SIZE(64)
    ) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_fdi_pl_state_sts(i_fdi_pl_state_sts),
        .i_rdi_pl_valid    (i_rdi_pl_valid),
        .i_rdi_pl_data     (i_rdi_pl_data),
        .i_fdi_lp_rxrdy    (i_fdi_lp_rxrdy),
        .o_fdi_pl_valid    (o_fdi_pl_valid),
        .o_fdi_pl_data     (o_fdi_pl_data),
        .o_rx_overf_err    (o_rx_overf_err),
        .o_rx_fifo_level   (o_rx_fifo_level)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: mode 0 = link down, 1 = receiving, 2 = overflowed; mq holds buffered flits.
    logic [63:0] mq[$];
    int          mmode = 0;

    task automatic model_edge();
        bit pop_e;
        bit push_e;
        if (i_rst) begin
            mq.delete();
            mmode = 0;
        end else if (mmode == 0) begin
            if (i_fdi_pl_state_sts == STS_ACTIVE) mmode = 1;
        end else if (i_fdi_pl_state_sts != STS_ACTIVE) begin
            mmode = 0;
            mq.delete();
        end else begin
            pop_e  = (mq.size() > 0) && i_fdi_lp_rxrdy;
            push_e = (mmode == 1) && i_rdi_pl_valid && ((mq.size() < 8) || pop_e);
            if (mmode == 1 && i_rdi_pl_valid && mq.size() == 8 && !pop_e) mmode = 2;
            if (pop_e) void'(mq.pop_front());
            if (push_e) mq.push_back(i_rdi_pl_data);
        end
    endtask

    task automatic cycle();
        @(posedge i_clk);
        model_edge();
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic drive(input logic [3:0] sts, input logic vld, input logic [63:0] d, input logic rdy);
        i_fdi_pl_state_sts = sts;
        i_rdi_pl_valid     = vld;
        i_rdi_pl_data      = d;
        i_fdi_lp_rxrdy     = rdy;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        drive(4'd0, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 2; i++) cycle();
        n_tests++;
        if ({o_fdi_pl_valid, o_rx_overf_err, o_rx_fifo_level, o_fdi_pl_data} !== 70'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b e=%b lvl=%0d data=%h, want all 0",
                     o_fdi_pl_valid, o_rx_overf_err, o_rx_fifo_level, o_fdi_pl_data);
        end
        i_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(4'd0, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            cycle();
            n_tests++;
            if ({o_fdi_pl_valid, o_rx_overf_err, o_rx_fifo_level} !== 6'd0 ||
                mmode != 0 || mq.size() != 0) begin
                n_fail++;
                $display("FAIL idle_ignored cyc %0d: got v=%b e=%b lvl=%0d, want 0 0 0",
                         cyc, o_fdi_pl_valid, o_rx_overf_err, o_rx_fifo_level);
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_passthrough();
        logic [63:0] flits [4];
        int          vcount;
        flits[0] = 64'h0001_0002_0003_0004;
        flits[1] = 64'h0005_0006_0007_0008;
        flits[2] = 64'h0009_000A_000B_000C;
        flits[3] = 64'h000D_000E_000F_000F;
        vcount = 0;
        drive(STS_ACTIVE, 1'b0, 64'd0, 1'b1);
        cycle();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(STS_ACTIVE, 1'b1, flits[i], 1'b1);
            else drive(STS_ACTIVE, 1'b0, 64'd0, 1'b1);
            cycle();
            if (o_fdi_pl_valid === 1'b1) vcount++;
            n_tests++;
            if (i < 4 && (o_fdi_pl_valid !== 1'b1 || o_fdi_pl_data !== flits[i] || o_rx_overf_err !== 1'b0)) begin
                n_fail++;
                $display("FAIL passthrough_flit%0d: got v=%b data=%h e=%b, want v=1 data=%h e=0",
                         i, o_fdi_pl_valid, o_fdi_pl_data, o_rx_overf_err, flits[i]);
            end else if (i >= 4 && (o_fdi_pl_valid !== 1'b0 || o_rx_fifo_level !== 4'd0)) begin
                n_fail++;
                $display("FAIL passthrough_drained: got v=%b lvl=%0d, want v=0 lvl=0",
                         o_fdi_pl_valid, o_rx_fifo_level);
            end
        end
        n_tests++;
        if (vcount != 4) begin
            n_fail++;
            $display("FAIL passthrough_valid_cycles: got %0d, want 4", vcount);
        end
        $display("[TB] test_passthrough done");
    endtask

    task automatic test_overflow();
        logic [63:0] saved [8];
        for (int i = 0; i < 8; i++) begin
            saved[i] = {$urandom, $urandom};
            drive(STS_ACTIVE, 1'b1, saved[i], 1'b0);
            cycle();
        end
        n_tests++;
        if (o_rx_fifo_level !== 4'd8 || o_rx_overf_err !== 1'b0 || o_fdi_pl_data !== saved[0]) begin
            n_fail++;
            $display("FAIL overflow_full: got lvl=%0d e=%b head=%h, want lvl=8 e=0 head=%h",
                     o_rx_fifo_level, o_rx_overf_err, o_fdi_pl_data, saved[0]);
        end
        drive(STS_ACTIVE, 1'b1, {$urandom, $urandom}, 1'b0);
        cycle();
        n_tests++;
        if (o_rx_fifo_level !== 4'd8 || o_rx_overf_err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_event: got lvl=%0d e=%b, want lvl=8 e=1", o_rx_fifo_level, o_rx_overf_err);
        end
        // Flits offered while overflowed must be dropped even as the buffer drains.
        for (int i = 0; i < 9; i++) begin
            drive(STS_ACTIVE, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'b1);
            cycle();
            n_tests++;
            if (i < 7 && (o_fdi_pl_valid !== 1'b1 || o_fdi_pl_data !== saved[i + 1] || o_rx_overf_err !== 1'b1)) begin
                n_fail++;
                $display("FAIL overflow_drain%0d: got v=%b data=%h e=%b, want v=1 data=%h e=1",
                         i, o_fdi_pl_valid, o_fdi_pl_data, o_rx_overf_err, saved[i + 1]);
            end else if (i >= 7 && (o_fdi_pl_valid !== 1'b0 || o_rx_overf_err !== 1'b1 || o_rx_fifo_level !== 4'd0)) begin
                n_fail++;
                $display("FAIL overflow_after_drain: got v=%b e=%b lvl=%0d, want v=0 e=1 lvl=0",
                         o_fdi_pl_valid, o_rx_overf_err, o_rx_fifo_level);
            end
        end
        $display("[TB] test_overflow done");
    endtask

    task automatic test_full_rw();
        drive(4'd0, 1'b0, 64'd0, 1'b0);
        cycle();
        drive(STS_ACTIVE, 1'b0, 64'd0, 1'b0);
        cycle();
        for (int i = 0; i < 8; i++) begin
            drive(STS_ACTIVE, 1'b1, {$urandom, $urandom}, 1'b0);
            cycle();
        end
        for (int i = 0; i < 20; i++) begin
            drive(STS_ACTIVE, 1'b1, {$urandom, $urandom}, 1'b1);
            cycle();
            n_tests++;
            if (o_fdi_pl_valid !== 1'b1 || o_rx_overf_err !== 1'b0 || o_rx_fifo_level !== 4'd8 ||
                mq.size() != 8 || o_fdi_pl_data !== mq[0]) begin
                n_fail++;
                $display("FAIL full_rw cyc %0d: got v=%b e=%b lvl=%0d data=%h, want v=1 e=0 lvl=8 data=%h",
                         cyc, o_fdi_pl_valid, o_rx_overf_err, o_rx_fifo_level, o_fdi_pl_data, mq[0]);
            end
        end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_link_loss();
        logic [63:0] fresh [3];
        drive(4'd0, 1'b0, 64'd0, 1'b0);
        cycle();
        drive(STS_ACTIVE, 1'b0, 64'd0, 1'b0);
        cycle();
        for (int i = 0; i < 5; i++) begin
            drive(STS_ACTIVE, 1'b1, {$urandom, $urandom}, 1'b0);
            cycle();
        end
        n_tests++;
        if (o_rx_fifo_level !== 4'd5) begin
            n_fail++;
            $display("FAIL link_loss_prefill: got lvl=%0d, want 5", o_rx_fifo_level);
        end
        drive(STS_LINK_ERROR, 1'b1, {$urandom, $urandom}, 1'b1);
        cycle();
        n_tests++;
        if (o_fdi_pl_valid !== 1'b0 || o_rx_fifo_level !== 4'd0 || o_rx_overf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL link_loss_flush: got v=%b lvl=%0d e=%b, want v=0 lvl=0 e=0",
                     o_fdi_pl_valid, o_rx_fifo_level, o_rx_overf_err);
        end
        drive(STS_ACTIVE, 1'b0, 64'd0, 1'b1);
        cycle();
        for (int i = 0; i < 3; i++) begin
            fresh[i] = {$urandom, $urandom};
            drive(STS_ACTIVE, 1'b1, fresh[i], 1'b1);
            cycle();
            n_tests++;
            if (o_fdi_pl_valid !== 1'b1 || o_fdi_pl_data !== fresh[i] || o_rx_overf_err !== 1'b0) begin
                n_fail++;
                $display("FAIL link_loss_new%0d: got v=%b data=%h e=%b, want v=1 data=%h e=0",
                         i, o_fdi_pl_valid, o_fdi_pl_data, o_rx_overf_err, fresh[i]);
            end
        end
        drive(STS_ACTIVE, 1'b0, 64'd0, 1'b1);
        cycle();
        $display("[TB] test_link_loss done");
    endtask

    task automatic test_reset_mid();
        logic [63:0] d;
        for (int i = 0; i < 9; i++) begin
            drive(STS_ACTIVE, 1'b1, {$urandom, $urandom}, 1'b0);
            cycle();
        end
        for (int i = 0; i < 2; i++) begin
            drive(STS_ACTIVE, 1'b0, 64'd0, 1'b1);
            cycle();
        end
        n_tests++;
        if (o_rx_fifo_level !== 4'd6 || o_rx_overf_err !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_setup: got lvl=%0d e=%b, want lvl=6 e=1", o_rx_fifo_level, o_rx_overf_err);
        end
        i_rst = 1'b1;
        drive(STS_ACTIVE, 1'b0, 64'd0, 1'b0);
        cycle();
        i_rst = 1'b0;
        n_tests++;
        if (o_rx_fifo_level !== 4'd0 || o_rx_overf_err !== 1'b0 || o_fdi_pl_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: got lvl=%0d e=%b v=%b, want 0 0 0",
                     o_rx_fifo_level, o_rx_overf_err, o_fdi_pl_valid);
        end
        cycle();
        d = {$urandom, $urandom};
        drive(STS_ACTIVE, 1'b1, d, 1'b0);
        cycle();
        n_tests++;
        if (o_fdi_pl_valid !== 1'b1 || o_rx_fifo_level !== 4'd1 || o_fdi_pl_data !== d) begin
            n_fail++;
            $display("FAIL reset_mid_reenter: got v=%b lvl=%0d data=%h, want v=1 lvl=1 data=%h",
                     o_fdi_pl_valid, o_rx_fifo_level, o_fdi_pl_data, d);
        end
        $display("[TB] test_reset_mid done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            i_rst = ($urandom_range(0, 99) == 0);
            drive(($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : STS_ACTIVE,
                  1'($urandom_range(0, 3) != 0), {$urandom, $urandom},
                  1'($urandom_range(0, 2) == 0 ? 0 : 1) & 1'(i % 64 < 48));
            cycle();
            n_tests++;
            if (o_fdi_pl_valid !== (mmode != 0 && mq.size() != 0) || o_rx_overf_err !== (mmode == 2) ||
                o_rx_fifo_level !== 4'(mq.size())) begin
                n_fail++;
                $display("FAIL random_status cyc %0d: got v=%b e=%b lvl=%0d, want v=%b e=%b lvl=%0d",
                         cyc, o_fdi_pl_valid, o_rx_overf_err, o_rx_fifo_level,
                         (mmode != 0 && mq.size() != 0), (mmode == 2), mq.size());
            end
            if (mmode != 0 && mq.size() != 0) begin
                n_tests++;
                if (o_fdi_pl_data !== mq[0]) begin
                    n_fail++;
                    $display("FAIL random_data cyc %0d: got %h, want %h", cyc, o_fdi_pl_data, mq[0]);
                end
            end
        end
        i_rst = 1'b0;
        $display("[TB] test_random done");
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_overflow();
        test_full_rw();
        test_link_loss();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
